// File: rtl/icache_refill.sv
// Miss-service engine for the instruction cache: fetches one word per miss from
// main memory over a req/gnt + rvalid bus, with timeout/retry, sticky error and flush abort.
module icache_refill #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cache_miss,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] write_data,
  output logic              fetch,
  output logic              busy,
  output logic              bus_error,
  output logic [CNT_W-1:0]  refill_count
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FILL  = 3'd3,
    DRAIN = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t           state_r;
  logic [TMR_W-1:0] timer_r;
  logic [RTY_W-1:0] retry_r;
  logic             timeout_s;
  logic             unused_s;

  assign timeout_s = (timer_r == TMR_W'(TIMEOUT - 1));
  // Requests are word-aligned, so the byte offset of the miss address is dropped.
  assign unused_s  = ^miss_addr[1:0];

  // Refill FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      timer_r      <= {TMR_W{1'b0}};
      retry_r      <= {RTY_W{1'b0}};
      mem_req      <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      write_data   <= {DATA_W{1'b0}};
      fetch        <= 1'b0;
      busy         <= 1'b0;
      bus_error    <= 1'b0;
      refill_count <= {CNT_W{1'b0}};
    end else begin
      fetch <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cache_miss && !flush) begin
            mem_addr <= {miss_addr[ADDR_W-1:2], 2'b00};
            retry_r  <= {RTY_W{1'b0}};
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            state_r  <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            // A granted request must still have its response drained on flush.
            mem_req <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
            state_r <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WAIT: begin
          timer_r <= timer_r + TMR_W'(1);
          if (flush) begin
            timer_r <= {TMR_W{1'b0}};
            state_r <= DRAIN;
          end else if (mem_rvalid) begin
            write_data <= mem_rdata;
            fetch      <= 1'b1;
            if (refill_count != {CNT_W{1'b1}}) begin
              refill_count <= refill_count + CNT_W'(1);
            end
            state_r <= FILL;
          end else if (timeout_s) begin
            if (retry_r < RTY_W'(MAX_RETRY)) begin
              retry_r <= retry_r + RTY_W'(1);
              mem_req <= 1'b1;
              state_r <= REQ;
            end else begin
              bus_error <= 1'b1;
              state_r   <= ERR;
            end
          end
        end
        FILL: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        DRAIN: begin
          timer_r <= timer_r + TMR_W'(1);
          if (mem_rvalid || timeout_s) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ERR: begin
          if (flush) begin
            bus_error <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: stimulus pushes expected refill words into a
// scoreboard queue that a negedge monitor pops whenever the DUT strobes fetch.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cache_miss = 1'b0;
  logic [19:0] miss_addr = 20'h0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] write_data;
  logic        fetch;
  logic        busy;
  logic        bus_error;
  logic [15:0] refill_count;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  icache_refill #(
    .ADDR_W(20), .DATA_W(32), .TIMEOUT(4), .MAX_RETRY(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cache_miss(cache_miss), .miss_addr(miss_addr),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .write_data(write_data),
    .fetch(fetch), .busy(busy), .bus_error(bus_error), .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every fetch strobe must match the oldest expected refill, data and cycle.
  always @(negedge clk) begin
    if (rst_n && fetch) begin
      if (q.size() == 0) begin
        check("unexpected_fetch", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("fetch_data", write_data, e.data);
        check("fetch_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [19:0] a);
    cache_miss = 1'b1;
    miss_addr  = a;
    step();
    cache_miss = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
  endtask

  task automatic return_word(input logic [31:0] d, input bit expect_fetch);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    if (expect_fetch) q.push_back('{data: d, cyc: cyc + 1});
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int extra_req;
    logic prev;

    step();
    step();
    check("reset_ctrl", {28'h0, mem_req, fetch, busy, bus_error}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", write_data, 32'h0);
    check("reset_count", refill_count, 32'h0);
    rst_n = 1'b1;
    step();

    // Basic refill: miss cyc0, gnt cyc2, rvalid cyc5, fetch cyc6.
    start_miss(20'h01234);
    check("t1_req", {31'h0, mem_req}, 32'h1);
    check("t1_addr", mem_addr, 32'h01234);
    check("t1_busy", {31'h0, busy}, 32'h1);
    step();
    grant();
    check("t1_req_drop", {31'h0, mem_req}, 32'h0);
    step();
    step();
    return_word(32'h00B70013, 1'b1);
    step();
    check("t1_count", refill_count, 32'd1);
    check("t1_idle", {30'h0, busy, fetch}, 32'h0);
    check("t1_wdata_held", write_data, 32'h00B70013);

    // Unaligned miss, grant withheld for 10 cycles.
    start_miss(20'h00FFF);
    for (int i = 0; i < 10; i++) begin
      check("t2_req_held", {31'h0, mem_req}, 32'h1);
      check("t2_addr_held", mem_addr, 32'h00FFC);
      step();
    end
    grant();
    return_word(32'hDEADBEEF, 1'b1);
    step();
    check("t2_count", refill_count, 32'd2);

    // No response at all: three request pulses, then sticky error.
    start_miss(20'h00100);
    pulses = 0;
    prev   = 1'b0;
    for (int i = 0; i < 60 && !bus_error; i++) begin
      if (mem_req && !prev) pulses++;
      prev    = mem_req;
      mem_gnt = mem_req;
      step();
    end
    mem_gnt = 1'b0;
    check("t3_bus_error", {31'h0, bus_error}, 32'h1);
    check("t3_req_pulses", pulses, 32'd3);
    check("t3_busy", {31'h0, busy}, 32'h1);
    extra_req = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) extra_req++;
      step();
    end
    check("t3_no_req_in_err", extra_req, 32'd0);
    check("t3_error_sticky", {31'h0, bus_error}, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_flush_clears", {30'h0, bus_error, busy}, 32'h0);
    check("t3_count", refill_count, 32'd2);

    // Flush in WAIT, late response is discarded.
    start_miss(20'h00200);
    grant();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    return_word(32'h11112222, 1'b0);
    check("t4_idle", {31'h0, busy}, 32'h0);
    check("t4_count", refill_count, 32'd2);

    // Response on the timeout cycle wins over retry.
    start_miss(20'h00400);
    grant();
    step();
    step();
    step();
    return_word(32'hCAFEF00D, 1'b1);
    extra_req = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) extra_req++;
      step();
    end
    check("t5_no_retry", extra_req, 32'd0);
    check("t5_count", refill_count, 32'd3);

    // Async reset in WAIT, later response must not produce a fetch.
    start_miss(20'h00300);
    grant();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ctrl", {28'h0, mem_req, fetch, busy, bus_error}, 32'h0);
    check("t6_async_addr", mem_addr, 32'h0);
    check("t6_async_wdata", write_data, 32'h0);
    check("t6_async_count", refill_count, 32'h0);
    step();
    rst_n = 1'b1;
    return_word(32'h55556666, 1'b0);
    step();
    check("t6_idle", {30'h0, busy, fetch}, 32'h0);
    check("t6_count", refill_count, 32'h0);

    step();
    check("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
